// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engine: register map, CTRL/STATUS bit
// positions and the transfer state encoding.
package dma_pkg;

  // Register word index, taken from address bits [3:2]
  localparam logic [1:0] OFF_SRC   = 2'd0;
  localparam logic [1:0] OFF_DST   = 2'd1;
  localparam logic [1:0] OFF_COUNT = 2'd2;
  localparam logic [1:0] OFF_CTRL  = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_SRC_INC  = 1;
  localparam int CTRL_DST_INC  = 2;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int CTRL_CLR_DONE = 4;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_IRQ_EN = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    LATCH = 2'd2,
    WR    = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dma_if.sv
// CPU-side and decoder-side data bus signals seen by the DMA engine.
// slave = the engine's view, master = the surrounding SoC's view.
interface dma_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wenable;
  logic        cpu_rreq;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wenable;
  logic [31:0] bus_rdata;
  logic        irq;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wenable, cpu_rreq, bus_rdata,
    output cpu_rdata, cpu_stall, bus_addr, bus_wdata, bus_wenable, irq
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_wenable, cpu_rreq, bus_rdata,
    input  cpu_rdata, cpu_stall, bus_addr, bus_wdata, bus_wenable, irq
  );
endinterface

// File: rtl/dma_arbiter.sv
// Data-bus arbiter: CPU has priority, but a DMA request denied STARVE_LIMIT
// consecutive cycles is granted on the next one.
module dma_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_dma_req,
  input  logic i_cpu_bus_req,
  output logic o_dma_grant,
  output logic o_cpu_stall
);

  logic [7:0] r_starve;

  assign o_dma_grant = i_dma_req & (~i_cpu_bus_req | (r_starve == 8'(STARVE_LIMIT)));
  assign o_cpu_stall = i_cpu_bus_req & o_dma_grant;

  // DMA only drops its request in IDLE/LATCH, and LATCH always follows a grant,
  // so clearing on !i_dma_req is the same as clearing in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 8'd0;
    end else if (!i_dma_req || o_dma_grant) begin
      r_starve <= 8'd0;
    end else begin
      r_starve <= r_starve + 8'd1;
    end
  end

endmodule

// File: rtl/dma_engine.sv
// Memory-mapped block-copy DMA engine sitting between the CPU data port and
// the SoC decoder, sharing the single data bus with the CPU.
module dma_engine
  import dma_pkg::*;
#(
  parameter logic [31:0] REG_BASE     = 32'h1FFF_FFF0,
  parameter int          STARVE_LIMIT = 8
) (
  input logic  clk,
  input logic  rst_n,
  dma_if.slave io
);

  dma_state_t  r_state, w_state_nxt;
  logic [31:0] r_src, r_dst, r_hold, r_rd_data;
  logic [15:0] r_count;
  logic        r_src_inc, r_dst_inc, r_irq_en, r_done, r_rd_hit;

  logic        w_hit, w_reg_wr, w_ctrl_wr, w_start, w_busy;
  logic        w_cpu_bus_req, w_dma_req, w_grant, w_stall, w_wr_grant;
  logic [1:0]  w_off;
  logic [31:0] w_dma_addr, w_reg_rdata;
  logic [3:0]  w_dma_we;

  assign w_hit         = (io.cpu_addr[31:4] == REG_BASE[31:4]);
  assign w_off         = io.cpu_addr[3:2];
  assign w_reg_wr      = w_hit & (io.cpu_wenable == 4'hF);
  assign w_ctrl_wr     = w_reg_wr & (w_off == OFF_CTRL);
  assign w_busy        = (r_state != IDLE);
  assign w_start       = w_ctrl_wr & io.cpu_wdata[CTRL_START] & ~w_busy;
  assign w_cpu_bus_req = (io.cpu_rreq | (|io.cpu_wenable)) & ~w_hit;
  assign w_dma_req     = (r_state == RD) | (r_state == WR);
  assign w_wr_grant    = (r_state == WR) & w_grant;

  dma_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_dma_req    (w_dma_req),
    .i_cpu_bus_req(w_cpu_bus_req),
    .o_dma_grant  (w_grant),
    .o_cpu_stall  (w_stall)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_dma_addr  = r_src;
    w_dma_we    = 4'h0;
    case (r_state)
      IDLE:  if (w_start && r_count != 16'd0) w_state_nxt = RD;
      RD:    if (w_grant) w_state_nxt = LATCH;
      LATCH: w_state_nxt = WR;
      WR: begin
        w_dma_addr = r_dst;
        w_dma_we   = 4'hF;
        if (w_grant) w_state_nxt = (r_count == 16'd1) ? IDLE : RD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_reg_rdata = 32'd0;
    case (w_off)
      OFF_SRC:   w_reg_rdata = r_src;
      OFF_DST:   w_reg_rdata = r_dst;
      OFF_COUNT: w_reg_rdata = {16'd0, r_count};
      default: begin
        w_reg_rdata[STAT_BUSY]   = w_busy;
        w_reg_rdata[STAT_DONE]   = r_done;
        w_reg_rdata[STAT_IRQ_EN] = r_irq_en;
      end
    endcase
  end

  // A granted DMA access takes the whole bus, so a stalled CPU store is dropped.
  assign io.bus_addr    = w_grant ? w_dma_addr : io.cpu_addr;
  assign io.bus_wdata   = w_grant ? r_hold     : io.cpu_wdata;
  assign io.bus_wenable = w_grant ? w_dma_we   : (w_hit ? 4'h0 : io.cpu_wenable);
  assign io.cpu_rdata   = r_rd_hit ? r_rd_data : io.bus_rdata;
  assign io.cpu_stall   = w_stall;
  assign io.irq         = r_done & r_irq_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_src     <= 32'd0;
      r_dst     <= 32'd0;
      r_count   <= 16'd0;
      r_hold    <= 32'd0;
      r_src_inc <= 1'b0;
      r_dst_inc <= 1'b0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_rd_hit  <= 1'b0;
      r_rd_data <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_hit  <= w_hit & io.cpu_rreq;
      r_rd_data <= w_reg_rdata;

      if (w_reg_wr && !w_busy) begin
        case (w_off)
          OFF_SRC:   r_src   <= io.cpu_wdata;
          OFF_DST:   r_dst   <= io.cpu_wdata;
          OFF_COUNT: r_count <= io.cpu_wdata[15:0];
          default:   ;
        endcase
      end

      if (w_ctrl_wr) begin
        r_irq_en <= io.cpu_wdata[CTRL_IRQ_EN];
        if (io.cpu_wdata[CTRL_CLR_DONE]) r_done <= 1'b0;
      end

      // A zero-length start completes at once without touching the bus.
      if (w_start) begin
        r_src_inc <= io.cpu_wdata[CTRL_SRC_INC];
        r_dst_inc <= io.cpu_wdata[CTRL_DST_INC];
        r_done    <= (r_count == 16'd0);
      end

      if (r_state == LATCH) r_hold <= io.bus_rdata;

      if (w_wr_grant) begin
        if (r_src_inc) r_src <= r_src + 32'd4;
        if (r_dst_inc) r_dst <= r_dst + 32'd4;
        r_count <= r_count - 16'd1;
        if (r_count == 16'd1) r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
// Directed testbench for dma_engine: a simple RAM model answers bus reads and
// a monitor logs every bus write with its cycle number.
module tb_dma_engine;
  localparam logic [31:0] REG_BASE = 32'h1FFF_FFF0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  dma_if bus_if ();

  dma_engine #(.REG_BASE(REG_BASE), .STARVE_LIMIT(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // RAM model: address seen mid-cycle, data returned in the following cycle
  logic [31:0] samp_addr = 32'd0;
  always @(negedge clk) samp_addr = bus_if.bus_addr;
  always @(posedge clk) bus_if.bus_rdata <= ram_word(samp_addr);

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  always @(negedge clk) begin
    if (rst_n && bus_if.bus_wenable != 4'h0) begin
      wq_addr.push_back(bus_if.bus_addr);
      wq_data.push_back(bus_if.bus_wdata);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic wq_clear();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic reg_write(input logic [3:0] off, input logic [31:0] data, input logic [3:0] we);
    bus_if.cpu_addr    = {REG_BASE[31:4], off};
    bus_if.cpu_wdata   = data;
    bus_if.cpu_wenable = we;
    @(posedge clk); #1;
    bus_if.cpu_addr    = 32'd0;
    bus_if.cpu_wdata   = 32'd0;
    bus_if.cpu_wenable = 4'h0;
  endtask

  task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data);
    bus_if.cpu_addr = addr;
    bus_if.cpu_rreq = 1'b1;
    @(posedge clk); #1;
    bus_if.cpu_rreq = 1'b0;
    bus_if.cpu_addr = 32'd0;
    @(negedge clk);
    data = bus_if.cpu_rdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus_if.cpu_addr = 32'h0000_1234; bus_if.cpu_wdata = 32'hA5A5_5A5A;
    bus_if.cpu_wenable = 4'h0; bus_if.cpu_rreq = 1'b0;
    @(negedge clk);
    n_chk++; if (bus_if.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", bus_if.cpu_stall); end
    n_chk++; if (bus_if.irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", bus_if.irq); end
    n_chk++; if (bus_if.bus_wenable !== 4'h0) begin n_fail++; $display("FAIL rst_we: got %h want 0", bus_if.bus_wenable); end
    n_chk++; if (bus_if.bus_addr !== 32'h0000_1234) begin n_fail++; $display("FAIL rst_addr: got %h want 00001234", bus_if.bus_addr); end
    n_chk++; if (bus_if.bus_wdata !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL rst_wdata: got %h want a5a55a5a", bus_if.bus_wdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_if.cpu_addr = 32'd0; bus_if.cpu_wdata = 32'd0;
    @(posedge clk); #1;
    cpu_read(REG_BASE + 32'hC, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_status: got %h want 0", d); end
    cpu_read(REG_BASE + 32'h8, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_count: got %h want 0", d); end
  endtask

  task automatic test_reg_isolation();
    logic [31:0] d;
    wq_clear();
    bus_if.cpu_addr = REG_BASE; bus_if.cpu_wdata = 32'h1234_5678; bus_if.cpu_wenable = 4'hF;
    @(negedge clk);
    n_chk++; if (bus_if.bus_wenable !== 4'h0) begin n_fail++; $display("FAIL iso_we: got %h want 0", bus_if.bus_wenable); end
    n_chk++; if (bus_if.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL iso_stall: got %b want 0", bus_if.cpu_stall); end
    @(posedge clk); #1;
    bus_if.cpu_wenable = 4'h0; bus_if.cpu_addr = 32'd0; bus_if.cpu_wdata = 32'd0;
    cpu_read(REG_BASE, d);
    n_chk++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL iso_readback: got %h want 12345678", d); end
    n_chk++; if (wq_addr.size() !== 0) begin n_fail++; $display("FAIL iso_buswrites: got %0d want 0", wq_addr.size()); end
  endtask

  task automatic test_copy();
    logic [31:0] d;
    int t0;
    reg_write(4'h0, 32'h0000_0100, 4'hF);
    reg_write(4'h4, 32'h4000_0000, 4'hF);
    reg_write(4'h8, 32'd4, 4'hF);
    wq_clear();
    t0 = cyc;
    reg_write(4'hC, 32'h0000_000F, 4'hF);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 12) begin n_chk++; if (bus_if.irq !== 1'b0) begin n_fail++; $display("FAIL copy_irq_early: got %b want 0", bus_if.irq); end end
      if (k == 13) begin n_chk++; if (bus_if.irq !== 1'b1) begin n_fail++; $display("FAIL copy_irq_done: got %b want 1", bus_if.irq); end end
    end
    @(posedge clk); #1;
    n_chk++; if (wq_addr.size() !== 4) begin n_fail++; $display("FAIL copy_nwrites: got %0d want 4", wq_addr.size()); end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      n_chk++; if (wq_addr[i] !== 32'h4000_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL copy_addr%0d: got %h want %h", i, wq_addr[i], 32'h4000_0000 + 32'(4 * i)); end
      n_chk++; if (wq_data[i] !== ram_word(32'h100 + 32'(4 * i))) begin n_fail++; $display("FAIL copy_data%0d: got %h want %h", i, wq_data[i], ram_word(32'h100 + 32'(4 * i))); end
      n_chk++; if (wq_cyc[i] - t0 !== 3 * (i + 1)) begin n_fail++; $display("FAIL copy_cycle%0d: got %0d want %0d", i, wq_cyc[i] - t0, 3 * (i + 1)); end
    end
    cpu_read(REG_BASE + 32'hC, d);
    n_chk++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL copy_status: got %h want 0000000a", d); end
    reg_write(4'hC, 32'h0000_0010, 4'hF);
    @(negedge clk);
    n_chk++; if (bus_if.irq !== 1'b0) begin n_fail++; $display("FAIL copy_irq_clear: got %b want 0", bus_if.irq); end
    @(posedge clk); #1;
    cpu_read(REG_BASE + 32'hC, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL copy_status_clr: got %h want 0", d); end
  endtask

  task automatic test_fixed_dst();
    logic [31:0] d;
    reg_write(4'h0, 32'h0000_0200, 4'hF);
    reg_write(4'h4, 32'h4000_0100, 4'hF);
    reg_write(4'h8, 32'd3, 4'hF);
    wq_clear();
    reg_write(4'hC, 32'h0000_0003, 4'hF);
    repeat (11) @(posedge clk);
    #1;
    n_chk++; if (wq_addr.size() !== 3) begin n_fail++; $display("FAIL fix_nwrites: got %0d want 3", wq_addr.size()); end
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      n_chk++; if (wq_addr[i] !== 32'h4000_0100) begin n_fail++; $display("FAIL fix_addr%0d: got %h want 40000100", i, wq_addr[i]); end
      n_chk++; if (wq_data[i] !== ram_word(32'h200 + 32'(4 * i))) begin n_fail++; $display("FAIL fix_data%0d: got %h want %h", i, wq_data[i], ram_word(32'h200 + 32'(4 * i))); end
    end
    n_chk++; if (bus_if.irq !== 1'b0) begin n_fail++; $display("FAIL fix_irq: got %b want 0", bus_if.irq); end
    cpu_read(REG_BASE + 32'hC, d);
    n_chk++; if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL fix_status: got %h want 00000002", d); end
    cpu_read(REG_BASE, d);
    n_chk++; if (d !== 32'h0000_020C) begin n_fail++; $display("FAIL fix_src_end: got %h want 0000020c", d); end
    cpu_read(REG_BASE + 32'h4, d);
    n_chk++; if (d !== 32'h4000_0100) begin n_fail++; $display("FAIL fix_dst_end: got %h want 40000100", d); end
    cpu_read(REG_BASE + 32'h8, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL fix_count_end: got %h want 0", d); end
  endtask

  task automatic test_count_zero();
    logic [31:0] d;
    reg_write(4'hC, 32'h0000_0010, 4'hF);
    reg_write(4'h8, 32'd0, 4'hF);
    wq_clear();
    reg_write(4'hC, 32'h0000_0001, 4'hF);
    cpu_read(REG_BASE + 32'hC, d);
    n_chk++; if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL zero_status: got %h want 00000002", d); end
    repeat (4) @(posedge clk);
    #1;
    n_chk++; if (wq_addr.size() !== 0) begin n_fail++; $display("FAIL zero_buswrites: got %0d want 0", wq_addr.size()); end
  endtask

  task automatic test_partial_write();
    logic [31:0] d;
    reg_write(4'h8, 32'd5, 4'hF);
    reg_write(4'h8, 32'h0000_0077, 4'h3);
    cpu_read(REG_BASE + 32'h8, d);
    n_chk++; if (d !== 32'd5) begin n_fail++; $display("FAIL part_count: got %h want 00000005", d); end
    reg_write(4'h0, 32'hFFFF_0000, 4'hC);
    cpu_read(REG_BASE, d);
    n_chk++; if (d !== 32'h0000_020C) begin n_fail++; $display("FAIL part_src: got %h want 0000020c", d); end
    wq_clear();
    reg_write(4'hC, 32'h0000_0001, 4'h1);
    cpu_read(REG_BASE + 32'hC, d);
    n_chk++; if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL part_start: got %h want 00000002", d); end
    n_chk++; if (wq_addr.size() !== 0) begin n_fail++; $display("FAIL part_buswrites: got %0d want 0", wq_addr.size()); end
  endtask

  task automatic test_busy_guard();
    logic [31:0] d;
    reg_write(4'h0, 32'h0000_0300, 4'hF);
    reg_write(4'h4, 32'h4000_0200, 4'hF);
    reg_write(4'h8, 32'd2, 4'hF);
    wq_clear();
    reg_write(4'hC, 32'h0000_0007, 4'hF);
    reg_write(4'h0, 32'hDEAD_0000, 4'hF);
    reg_write(4'h4, 32'hBEEF_0000, 4'hF);
    repeat (6) @(posedge clk);
    #1;
    cpu_read(REG_BASE, d);
    n_chk++; if (d !== 32'h0000_0308) begin n_fail++; $display("FAIL busy_src: got %h want 00000308", d); end
    cpu_read(REG_BASE + 32'h4, d);
    n_chk++; if (d !== 32'h4000_0208) begin n_fail++; $display("FAIL busy_dst: got %h want 40000208", d); end
    n_chk++; if (wq_addr.size() !== 2) begin n_fail++; $display("FAIL busy_nwrites: got %0d want 2", wq_addr.size()); end
    if (wq_addr.size() == 2) begin
      n_chk++; if (wq_data[1] !== ram_word(32'h304)) begin n_fail++; $display("FAIL busy_data1: got %h want %h", wq_data[1], ram_word(32'h304)); end
      n_chk++; if (wq_addr[1] !== 32'h4000_0204) begin n_fail++; $display("FAIL busy_addr1: got %h want 40000204", wq_addr[1]); end
    end
  endtask

  task automatic test_contention();
    logic [31:0] addr_cur, pend_addr;
    logic        pend, stalled, exp_stall;
    int          t0;
    reg_write(4'h0, 32'h0000_0500, 4'hF);
    reg_write(4'h4, 32'h4000_0300, 4'hF);
    reg_write(4'h8, 32'd1, 4'hF);
    wq_clear();
    t0 = cyc;
    reg_write(4'hC, 32'h0000_0007, 4'hF);
    addr_cur = 32'h0000_0800;
    pend = 1'b0;
    pend_addr = 32'd0;
    for (int k = 1; k <= 22; k++) begin
      bus_if.cpu_addr = addr_cur;
      bus_if.cpu_rreq = 1'b1;
      @(negedge clk);
      if (pend) begin
        n_chk++; if (bus_if.cpu_rdata !== ram_word(pend_addr)) begin n_fail++; $display("FAIL cont_load k=%0d: got %h want %h", k, bus_if.cpu_rdata, ram_word(pend_addr)); end
      end
      stalled = bus_if.cpu_stall;
      exp_stall = (k == 9) || (k == 19);
      n_chk++; if (stalled !== exp_stall) begin n_fail++; $display("FAIL cont_stall k=%0d: got %b want %b", k, stalled, exp_stall); end
      if (stalled) begin
        pend = 1'b0;
      end else begin
        pend = 1'b1;
        pend_addr = addr_cur;
        addr_cur = addr_cur + 32'd4;
      end
      @(posedge clk); #1;
    end
    bus_if.cpu_rreq = 1'b0;
    bus_if.cpu_addr = 32'd0;
    @(negedge clk);
    n_chk++; if (bus_if.cpu_rdata !== ram_word(pend_addr)) begin n_fail++; $display("FAIL cont_last_load: got %h want %h", bus_if.cpu_rdata, ram_word(pend_addr)); end
    @(posedge clk); #1;
    n_chk++; if (wq_addr.size() !== 1) begin n_fail++; $display("FAIL cont_nwrites: got %0d want 1", wq_addr.size()); end
    if (wq_addr.size() == 1) begin
      n_chk++; if (wq_addr[0] !== 32'h4000_0300) begin n_fail++; $display("FAIL cont_waddr: got %h want 40000300", wq_addr[0]); end
      n_chk++; if (wq_data[0] !== ram_word(32'h500)) begin n_fail++; $display("FAIL cont_wdata: got %h want %h", wq_data[0], ram_word(32'h500)); end
      n_chk++; if (wq_cyc[0] - t0 !== 19) begin n_fail++; $display("FAIL cont_wcycle: got %0d want 19", wq_cyc[0] - t0); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int t0;
    reg_write(4'hC, 32'h0000_0010, 4'hF);
    reg_write(4'h0, 32'h0000_0600, 4'hF);
    reg_write(4'h4, 32'h4000_0400, 4'hF);
    reg_write(4'h8, 32'd4, 4'hF);
    wq_clear();
    t0 = cyc;
    reg_write(4'hC, 32'h0000_000F, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (bus_if.bus_wenable !== 4'h0) begin n_fail++; $display("FAIL rmid_we: got %h want 0", bus_if.bus_wenable); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_chk++; if (wq_addr.size() !== 1) begin n_fail++; $display("FAIL rmid_nwrites: got %0d want 1", wq_addr.size()); end
    if (wq_addr.size() >= 1) begin
      n_chk++; if (wq_cyc[0] - t0 !== 3) begin n_fail++; $display("FAIL rmid_wcycle: got %0d want 3", wq_cyc[0] - t0); end
    end
    n_chk++; if (bus_if.irq !== 1'b0) begin n_fail++; $display("FAIL rmid_irq: got %b want 0", bus_if.irq); end
    cpu_read(REG_BASE + 32'hC, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rmid_status: got %h want 0", d); end
    cpu_read(REG_BASE, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rmid_src: got %h want 0", d); end
  endtask

  initial begin
    bus_if.cpu_addr    = 32'd0;
    bus_if.cpu_wdata   = 32'd0;
    bus_if.cpu_wenable = 4'h0;
    bus_if.cpu_rreq    = 1'b0;
    test_reset();
    test_reg_isolation();
    test_copy();
    test_fixed_dst();
    test_count_zero();
    test_partial_write();
    test_busy_guard();
    test_contention();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
